// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART command frames ('W'/'R') to single-beat bus reads/writes, status/data back to UART.
// Optional macro UART_BUS_BRIDGE_FRAME_TIMEOUT_EN aborts a frame whose bytes stop arriving.
module uart_bus_bridge #(
    parameter int ADDR_WIDTH    = 32,
    parameter int ACK_TIMEOUT   = 1024,
    parameter int FRAME_TIMEOUT = 100000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_data_ready,
    input  logic [7:0]            i_rx_data,
    output logic                  o_tx_start,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_done,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic                  o_read,
    output logic                  o_write,
    output logic [31:0]           o_writedata,
    input  logic [31:0]           i_readdata,
    input  logic                  i_acknowledge,
    output logic                  o_busy
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS, SEND, WAIT_TX} state_t;

    state_t        state, state_n;
    logic          is_write;
    logic [1:0]    cnt;
    logic [1:0]    left;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   resp;
    logic [TW-1:0] tmo;
    logic          last_byte;
    logic          tmo_hit;
    logic          frame_abort;

    assign last_byte   = i_rx_data_ready && cnt == 2'd3;
    assign tmo_hit     = tmo == TMO_LAST;
    assign o_address   = addr[ADDR_WIDTH-1:0];
    assign o_writedata = wdata;
    assign o_busy      = state != IDLE;

`ifdef UART_BUS_BRIDGE_FRAME_TIMEOUT_EN
    localparam int FW = $clog2(FRAME_TIMEOUT + 1);
    logic [FW-1:0] ftmo;
    logic          gap;
    assign gap         = (state == GET_ADDR || state == GET_DATA) && !i_rx_data_ready;
    assign frame_abort = gap && ftmo == FW'(FRAME_TIMEOUT - 1);
    // Idle-gap counter inside an open frame, restarted by every received byte
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) ftmo <= '0;
        else         ftmo <= gap ? ftmo + 1'b1 : '0;
`else
    // Without the idle-gap watchdog a partial frame simply waits for its remaining bytes
    assign frame_abort = FRAME_TIMEOUT < 0;
`endif

    // State register
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) state <= IDLE;
        else         state <= state_n;

    // Next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (i_rx_data_ready)
                          state_n = (i_rx_data == 8'h57 || i_rx_data == 8'h52) ? GET_ADDR : SEND;
            GET_ADDR: if (frame_abort) state_n = IDLE;
                      else if (last_byte) state_n = is_write ? GET_DATA : BUS;
            GET_DATA: if (frame_abort) state_n = IDLE;
                      else if (last_byte) state_n = BUS;
            BUS:      if (i_acknowledge || tmo_hit) state_n = SEND;
            SEND:     state_n = WAIT_TX;
            WAIT_TX:  if (i_tx_done) state_n = (left != 2'd0) ? SEND : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Frame collection, bus request and response shifting
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            is_write   <= 1'b0;
            cnt        <= 2'd0;
            left       <= 2'd0;
            addr       <= '0;
            wdata      <= '0;
            resp       <= '0;
            tmo        <= '0;
            o_read     <= 1'b0;
            o_write    <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            o_tx_start <= 1'b0;
            tmo        <= '0;
            case (state)
                IDLE: if (i_rx_data_ready) begin
                    is_write <= i_rx_data == 8'h57;
                    cnt      <= 2'd0;
                    resp     <= 32'h3F;
                    left     <= 2'd0;
                end
                GET_ADDR: if (i_rx_data_ready) begin
                    addr[{cnt, 3'b000} +: 8] <= i_rx_data;
                    cnt                      <= cnt + 2'd1;
                    if (cnt == 2'd3 && !is_write) o_read <= 1'b1;
                end
                GET_DATA: if (i_rx_data_ready) begin
                    wdata[{cnt, 3'b000} +: 8] <= i_rx_data;
                    cnt                       <= cnt + 2'd1;
                    if (cnt == 2'd3) o_write <= 1'b1;
                end
                BUS: begin
                    // Request drops on the edge that samples ack, so a one-cycle ack sees one request
                    if (i_acknowledge) begin
                        o_read  <= 1'b0;
                        o_write <= 1'b0;
                        resp    <= is_write ? 32'h4B : i_readdata;
                        left    <= is_write ? 2'd0 : 2'd3;
                    end else if (tmo_hit) begin
                        o_read  <= 1'b0;
                        o_write <= 1'b0;
                        resp    <= 32'h54;
                        left    <= 2'd0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= resp[7:0];
                end
                WAIT_TX: if (i_tx_done && left != 2'd0) begin
                    left <= left - 2'd1;
                    resp <= resp >> 8;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Host-side debug/loader bridge: parses command frames from a UART byte receiver and acts as a bus initiator.
- Issues single 32-bit reads and writes on the same read/write/acknowledge slave bus that the system peripherals respond to.
- Returns status or read data as bytes to a UART byte transmitter.
- Sits between the serial RX/TX byte cores and the system bus; lets a PC peek/poke memory and peripherals without the CPU.

Parameters:
- ADDR_WIDTH, 32, width of o_address; the received 32-bit address is truncated to the low ADDR_WIDTH bits.
- ACK_TIMEOUT, 1024, clock cycles to wait for i_acknowledge before aborting a bus cycle (must be >= 2).
- FRAME_TIMEOUT, 100000, idle cycles between bytes of one frame before the parser aborts (used only with the optional feature).

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high
- i_rx_data_ready  in  1  one-cycle pulse: new received byte on i_rx_data
- i_rx_data  in  8  received byte
- o_tx_start  out  1  one-cycle pulse: transmit o_tx_data
- o_tx_data  out  8  byte to transmit, held stable until i_tx_done
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte
- o_address  out  ADDR_WIDTH  bus address
- o_read  out  1  bus read request, level
- o_write  out  1  bus write request, level
- o_writedata  out  32  bus write data
- i_readdata  in  32  bus read data, valid in the cycle i_acknowledge is high
- i_acknowledge  in  1  one-cycle slave acknowledge
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; shift registers 0.
- Frame format:
  - Write: 0x57 ('W'), 4 address bytes LSB first, 4 data bytes LSB first.
  - Read: 0x52 ('R'), 4 address bytes LSB first.
- Responses:
  - Write ok: 0x4B ('K').
  - Read ok: 4 data bytes, LSB first.
  - Bus timeout: 0x54 ('T'), for either command.
  - Unknown command byte: 0x3F ('?').
- States:
  - IDLE: on i_rx_data_ready, 'W'/'R' latches the command, clears the counter and goes to GET_ADDR. Any other byte loads 0x3F and goes to SEND.
  - GET_ADDR: each i_rx_data_ready shifts the byte into addr[8*cnt+:8] and increments cnt. After the 4th byte: write goes to GET_DATA with cnt=0; read goes to BUS.
  - GET_DATA: same collection into wdata; after the 4th byte go to BUS.
  - BUS: o_read or o_write is registered high with o_address/o_writedata. They stay high until the edge where i_acknowledge is sampled high; they deassert on that same edge, so a slave that acks and returns to idle in one cycle never sees a second request.
    - Read ack: latch i_readdata into the response register.
    - Write ack: load 0x4B.
    - Timeout counter reaches ACK_TIMEOUT-1 without ack: deassert the request, load 0x54.
    - Then go to SEND.
  - SEND: pulse o_tx_start for exactly 1 cycle with o_tx_data = the current response byte, then go to WAIT_TX.
  - WAIT_TX: on i_tx_done, if more bytes remain (read data: 4 total), go to SEND with the next byte; else go to IDLE.
- RX bytes arriving in BUS, SEND or WAIT_TX are dropped; no buffering.
- Latency: bus request asserts 1 cycle after the final frame byte's pulse. First o_tx_start is 2 cycles after ack.
- Simultaneous ack and timeout-terminal cycle: the ack wins.
- Reset asserted mid-frame or mid-bus-cycle: immediate return to reset values; the bus request drops asynchronously.

Optional Feature:
- UART_BUS_BRIDGE_FRAME_TIMEOUT_EN
  - Defined: in GET_ADDR/GET_DATA, a counter clears on every i_rx_data_ready. Reaching FRAME_TIMEOUT aborts to IDLE silently, with no response and no bus cycle.
  - Undefined: no counter; a partial frame waits indefinitely.

Test Plan:
- Write: send 57 10 00 00 00 EF BE AD DE -> o_write=1, o_address=0x10, o_writedata=0xDEADBEEF; ack after 3 cycles -> o_write drops on the ack edge; TX byte 0x4B; o_busy returns to 0.
- Read: send 52 04 00 00 00; slave acks with i_readdata=0x00200000 -> o_read single request; TX bytes 00 00 20 00 in order, each o_tx_start only after the previous i_tx_done.
- Timeout: read of 0x8 with no ack -> o_read high for exactly ACK_TIMEOUT=16 cycles; TX 0x54.
- Bad command: send 0x41 -> TX 0x3F, no bus activity. Then a valid 'R' frame is processed normally.
- Reset mid-bus: assert i_reset while o_write=1 -> o_write=0 immediately; after release, a fresh write frame completes with 0x4B.
- With UART_BUS_BRIDGE_FRAME_TIMEOUT_EN, FRAME_TIMEOUT=50: send 57 10 then stall 60 cycles -> no bus cycle, no TX. The next 'W' frame starts a fresh parse.
